// File: rtl/alu_pkg.sv
// Shared definitions for the lab-3 ALU datapath and its sequencer.
//   - ALUControl opcode constants (0..9 are the implemented operations)
//   - seq_state_t: sequencer FSM states
//   - bit positions of the captured {N,Z,C,V} flag vector
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b0110;
  localparam logic [3:0] OP_SHL  = 4'b0111;
  localparam logic [3:0] OP_SHR  = 4'b1000;
  localparam logic [3:0] OP_PASS = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ERR  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Positions inside flags = {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequencing controller for the lab-3 ALU datapath.
// Accepts one request at a time (start/busy), latches opcode and operands,
// presents them to the combinational ALU for a per-opcode number of cycles,
// then captures the result and flags into a status register.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   start, op, a, b            request: opcode and operands
//   flags_clr                  synchronous clear of the captured flags
//   alu_ctrl, alu_a, alu_b     drive to the datapath (sole ALUControl writer)
//   alu_q, alu_z/n/v/c         datapath result and flag generator outputs
//   busy                       high while executing or reporting an error
//   done, err                  one-cycle completion pulse; err marks illegal op
//   result, flags              captured result and {N,Z,C,V}
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int         M         = 4,
  parameter int         ALU_LAT   = 1,
  parameter int         MULT_LAT  = 3,
  parameter int         NUM_OPS   = 10,
  parameter logic [3:0] IDLE_CTRL = 4'b1111
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         flags_clr,
  output logic [3:0]   alu_ctrl,
  output logic [M-1:0] alu_a,
  output logic [M-1:0] alu_b,
  input  logic [M-1:0] alu_q,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic         alu_v,
  input  logic         alu_c,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [M-1:0] result,
  output logic [3:0]   flags
);

  localparam int MAX_LAT = (MULT_LAT > ALU_LAT) ? MULT_LAT : ALU_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  // Counter preloads: EXEC lasts LAT cycles, capture happens when it hits 0.
  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MULT_LAT - 1);

  seq_state_t       state, state_nxt;
  logic [3:0]       op_q;
  logic [M-1:0]     a_q, b_q;
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  logic accept;
  logic op_legal;
  logic capture;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: state elements use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and decoded strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    op_legal  = (int'(op) < NUM_OPS);
    capture   = 1'b0;

    case (state)
      IDLE, DONE: begin
        // DONE accepts too, which gives back-to-back operation.
        if (start) begin
          accept    = 1'b1;
          state_nxt = op_legal ? EXEC : ERR;
        end else begin
          state_nxt = IDLE;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      ERR:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latches, latency counter and status register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else begin
      if (accept) begin
        op_q  <= op;
        a_q   <= a;
        b_q   <= b;
        err_q <= !op_legal;
        cnt   <= (op == OP_MUL) ? MUL_CNT : ALU_CNT;
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end

      // A capture on the same edge as flags_clr takes priority.
      if (capture) begin
        result         <= alu_q;
        flags[FLAG_N]  <= alu_n;
        flags[FLAG_Z]  <= alu_z;
        flags[FLAG_C]  <= alu_c;
        flags[FLAG_V]  <= alu_v;
      end else if (flags_clr) begin
        flags <= '0;
      end
    end
  end

  // All outputs decode registered state only, so they move at clock edges.
  // op_q is shown only in EXEC, so an illegal opcode never reaches the ALU.
  assign alu_ctrl = (state == EXEC) ? op_q : IDLE_CTRL;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign busy     = (state == EXEC) || (state == ERR);
  assign done     = (state == DONE);
  assign err      = (state == DONE) && err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU stand-in,
// a scoreboard of expected completions and a done-driven monitor.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int M        = 4;
  localparam int ALU_LAT  = 1;
  localparam int MULT_LAT = 3;
  localparam int NUM_OPS  = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [M-1:0] a = '0, b = '0;
  logic         flags_clr = 1'b0;
  logic [3:0]   alu_ctrl;
  logic [M-1:0] alu_a, alu_b, alu_q;
  logic         alu_z, alu_n, alu_v, alu_c;
  logic         busy, done, err;
  logic [M-1:0] result;
  logic [3:0]   flags;

  alu_op_sequencer #(
    .M(M), .ALU_LAT(ALU_LAT), .MULT_LAT(MULT_LAT), .NUM_OPS(NUM_OPS), .IDLE_CTRL(4'b1111)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flags_clr(flags_clr), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_q(alu_q), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c),
    .busy(busy), .done(done), .err(err), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Behavioural ALU + flag generator: returns {q, n, z, c, v}.
  // Any non-opcode control (idle) yields a recognisable junk pattern.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] dp_model(input logic [3:0] ctl, input logic [3:0] x, input logic [3:0] y);
    logic [4:0] s;
    logic [7:0] p;
    logic [3:0] q;
    logic c, v;
    c = 1'b0; v = 1'b0; s = '0; p = '0;
    case (ctl)
      4'd0: begin s = {1'b0, x} + {1'b0, y}; q = s[3:0]; c = s[4]; v = (x[3] == y[3]) && (q[3] != x[3]); end
      4'd1: begin s = {1'b0, x} - {1'b0, y}; q = s[3:0]; c = s[4]; v = (x[3] != y[3]) && (q[3] != x[3]); end
      4'd2: begin p = 8'(x) * 8'(y); q = p[3:0]; v = (p[7:4] != 4'd0); end
      4'd3: q = x & y;
      4'd4: q = x | y;
      4'd5: q = x ^ y;
      4'd6: q = ~x;
      4'd7: begin q = {x[2:0], 1'b0}; c = x[3]; end
      4'd8: begin q = {1'b0, x[3:1]}; c = x[0]; end
      4'd9: q = y;
      default: return {4'hA, 4'b1010};
    endcase
    return {q, q[3], (q == 4'd0), c, v};
  endfunction

  // Override lets a directed test force a specific datapath response.
  logic       ovr_en = 1'b0;
  logic [7:0] ovr_val = '0;
  logic [7:0] dp_out;
  always_comb begin
    dp_out = dp_model(alu_ctrl, alu_a, alu_b);
    if (ovr_en && alu_ctrl != 4'hF) dp_out = ovr_val;
  end
  assign {alu_q, alu_n, alu_z, alu_c, alu_v} = dp_out;

  // ---------------------------------------------------------------------------
  // Scoreboard, reference state, checker
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       err;
    logic [3:0] result;
    logic [3:0] flags;
    int         done_cyc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  logic [3:0] exp_result = '0;
  logic [3:0] exp_flags  = '0;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: counts cycles with a live opcode on alu_ctrl and compares each
  // done pulse against the oldest outstanding expectation.
  int act_cnt = 0;
  int bad_ctl = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act_cnt = 0;
        bad_ctl = 0;
      end else begin
        if (alu_ctrl != 4'hF) begin
          act_cnt++;
          if (int'(alu_ctrl) >= NUM_OPS) bad_ctl++;
        end
        if (done) begin
          if (sb.size() == 0) begin
            check("done_without_request", 32'(done), 32'd0);
          end else begin
            e = sb.pop_front();
            check("err",          32'(err),    32'(e.err));
            check("result",       32'(result), 32'(e.result));
            check("flags",        32'(flags),  32'(e.flags));
            check("done_cycle",   32'(cyc),    32'(e.done_cyc));
            check("ctrl_cycles",  32'(act_cnt), 32'(e.lat));
            check("busy_at_done", 32'(busy),   32'd0);
          end
          check("illegal_ctrl_seen", 32'(bad_ctl), 32'd0);
          act_cnt = 0;
        end
      end
    end
  end

  // Issue a request; call at a negedge with the DUT in IDLE or DONE.
  // Returns 1 time unit after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    logic [7:0] r;
    logic legal;
    legal = (int'(o) < NUM_OPS);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (legal) begin
      r = ovr_en ? ovr_val : dp_model(o, x, y);
      exp_result = r[7:4];
      exp_flags  = r[3:0];
      e.lat = (o == OP_MUL) ? MULT_LAT : ALU_LAT;
    end else begin
      e.lat = 0;
    end
    e.err      = !legal;
    e.result   = exp_result;
    e.flags    = exp_flags;
    e.done_cyc = cyc + (legal ? e.lat : 1);
    sb.push_back(e);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Pulse start for one edge while the DUT is busy; must be ignored.
  task automatic busy_start();
    @(negedge clk);
    start = 1'b1; op = 4'($urandom_range(0, 15)); a = 4'($urandom); b = 4'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Leaves the caller at the negedge where done is high (bounded).
  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'hF);
    check({tag, "_alu_a"},    32'(alu_a),    32'd0);
    check({tag, "_alu_b"},    32'(alu_b),    32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
    check({tag, "_result"},   32'(result),   32'd0);
    check({tag, "_flags"},    32'(flags),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] r_op;
    #2;
    check_reset("por");
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);

    // ADD with a forced datapath response Q=0, c=v=1
    ovr_en = 1'b1; ovr_val = {4'h0, 4'b0011};
    issue(OP_ADD, 4'd7, 4'd9);
    wait_done();
    ovr_en = 1'b0;
    idle_cycles(1);

    // MUL 3*6 = 18 -> Q=2, overflow
    issue(OP_MUL, 4'd3, 4'd6);
    wait_done();
    idle_cycles(1);

    // ADD then SUB accepted in the DONE cycle; a start during EXEC is ignored
    issue(OP_ADD, 4'd5, 4'd2);
    wait_done();
    issue(OP_SUB, 4'd9, 4'd4);
    busy_start();
    wait_done();
    idle_cycles(1);

    // Illegal opcode: result/flags held, err with done
    issue(4'b1110, 4'd1, 4'd1);
    busy_start();
    wait_done();
    idle_cycles(1);

    // flags_clr with nothing in progress
    flags_clr = 1'b1;
    @(posedge clk);
    #1;
    flags_clr = 1'b0;
    exp_flags = '0;
    @(negedge clk);
    check("clr_idle_flags",  32'(flags),  32'(exp_flags));
    check("clr_idle_result", 32'(result), 32'(exp_result));

    // flags_clr on the capture edge: capture wins (8+8 -> Q=0, Z,C,V set)
    issue(OP_ADD, 4'd8, 4'd8);
    flags_clr = 1'b1;
    wait_done();
    flags_clr = 1'b0;
    idle_cycles(1);

    // Randomized requests with random gaps, back-to-back and ignored starts
    for (int n = 0; n < 60; n++) begin
      r_op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(NUM_OPS, 15))
                                         : 4'($urandom_range(0, NUM_OPS - 1));
      issue(r_op, 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 1) == 1) busy_start();
      wait_done();
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(1);

    // Reset asserted mid-EXEC: immediate return to reset values, no done
    issue(OP_MUL, 4'd3, 4'd6);
    wait_done();
    idle_cycles(1);
    issue(OP_MUL, 4'd5, 4'd5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_exec");
    sb.delete();
    exp_result = '0;
    exp_flags  = '0;
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(6);

    // Recovery after reset
    issue(OP_ADD, 4'd1, 4'd2);
    wait_done();
    idle_cycles(2);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
